// File: rtl/gelato_exec_recv.sv
// gelato_exec_recv: receiving end of the operand-collector -> execute-unit
// channel. Each accepted bundle (instruction plus three warp operand
// registers) goes into a small pointer-based FIFO and is issued to the
// functional unit over a valid/ready handshake.
//
// Build option: define GELATO_EXEC_RECV_STATS_EN to add the stat_issued and
// stat_stall counter outputs.
//
// The wr/rd pointers carry one extra MSB used as a wrap bit. This bit is what
// tells a full FIFO apart from an empty one when the low bits are equal.
// count/full/empty are held in flops that are loaded from the next-pointer
// values. This keeps them free of any combinational path from the inputs.
module gelato_exec_recv #(
  parameter int INST_W = 64,
  parameter int REG_W  = 1024,
  parameter int DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   exec_valid,
  input  logic [INST_W-1:0]      exec_inst,
  input  logic [REG_W-1:0]       exec_rs1,
  input  logic [REG_W-1:0]       exec_rs2,
  input  logic [REG_W-1:0]       exec_rs3,
  output logic                   exec_clear,
  output logic                   fu_valid,
  input  logic                   fu_ready,
  output logic [INST_W-1:0]      fu_inst,
  output logic [REG_W-1:0]       fu_rs1,
  output logic [REG_W-1:0]       fu_rs2,
  output logic [REG_W-1:0]       fu_rs3,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
`ifdef GELATO_EXEC_RECV_STATS_EN
  ,
  output logic [31:0]            stat_issued,
  output logic [31:0]            stat_stall
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr_nxt;
  logic [PW-1:0]     rd_ptr_nxt;
  logic [PW-1:0]     count_q;
  logic [PW-1:0]     count_nxt;
  logic              full_q;
  logic              full_nxt;
  logic              empty_q;
  logic              empty_nxt;
  logic              push;
  logic              fu_fire;

  logic [INST_W-1:0] mem_inst [DEPTH];
  logic [REG_W-1:0]  mem_rs1  [DEPTH];
  logic [REG_W-1:0]  mem_rs2  [DEPTH];
  logic [REG_W-1:0]  mem_rs3  [DEPTH];

  // The push is gated only by registered full, so fu_ready never reaches
  // exec_clear. It is also held low while reset is asserted.
  assign push       = exec_valid & ~full_q & ~flush & rst_n;
  assign exec_clear = push;

  // While the FIFO is empty, fu_valid is low and fu_ready has no effect.
  assign fu_fire    = ~empty_q & fu_ready;

  assign fu_valid   = ~empty_q;
  assign full       = full_q;
  assign empty      = empty_q;
  assign count      = count_q;

  // Next-pointer and next-flag computation; flush overrides push and pop.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
    end else begin
      if (push) begin
        wr_ptr_nxt = wr_ptr + PW'(1);
      end
      if (fu_fire) begin
        rd_ptr_nxt = rd_ptr + PW'(1);
      end
    end
    count_nxt = wr_ptr_nxt - rd_ptr_nxt;
    empty_nxt = (wr_ptr_nxt == rd_ptr_nxt);
    full_nxt  = (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]) &&
                (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]);
  end

  // Pointer and occupancy-flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      count_q <= count_nxt;
      full_q  <= full_nxt;
      empty_q <= empty_nxt;
    end
  end

  // Bundle storage. It is not reset, because the contents only matter
  // while fu_valid is high.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst[wr_ptr[AW-1:0]] <= exec_inst;
      mem_rs1[wr_ptr[AW-1:0]]  <= exec_rs1;
      mem_rs2[wr_ptr[AW-1:0]]  <= exec_rs2;
      mem_rs3[wr_ptr[AW-1:0]]  <= exec_rs3;
    end
  end

  assign fu_inst = mem_inst[rd_ptr[AW-1:0]];
  assign fu_rs1  = mem_rs1[rd_ptr[AW-1:0]];
  assign fu_rs2  = mem_rs2[rd_ptr[AW-1:0]];
  assign fu_rs3  = mem_rs3[rd_ptr[AW-1:0]];

`ifdef GELATO_EXEC_RECV_STATS_EN
  logic [31:0] issued_q;
  logic [31:0] stall_q;

  // Free-running wrap-around counters; flush deliberately leaves them alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      if (fu_fire) begin
        issued_q <= issued_q + 32'd1;
      end
      if (exec_valid && full_q) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign stat_issued = issued_q;
  assign stat_stall  = stall_q;
`endif

endmodule

// File: doc/gelato_exec_recv.md
# gelato_exec_recv

Execute-unit front end that terminates the operand-collector → execute-unit instruction channel on the receiving side. It accepts an instruction with its three warp operand registers, acknowledges the collector by clearing the channel, and buffers the bundle in a small FIFO. It then issues the bundle to the functional-unit pipeline over a valid/ready handshake. It decouples collector timing from functional-unit back-pressure.

## Interface
Parameters:
- INST_W, 64, width of a packed `inst_t`.
- REG_W, 1024, width of a packed `warp_reg_t` (32 threads × 32 bits).
- DEPTH, 2, FIFO entries; power of two, ≥ 2.

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- exec_valid  input  1  collector presents a bundle.
- exec_inst  input  INST_W  instruction.
- exec_rs1 / exec_rs2 / exec_rs3  input  REG_W each  operands.
- exec_clear  output  1  receiver drives the channel valid low; the bundle is taken this cycle.
- fu_valid  output  1  head bundle available to the functional unit.
- fu_ready  input  1  functional unit accepts the head this cycle.
- fu_inst  output  INST_W  head instruction.
- fu_rs1 / fu_rs2 / fu_rs3  output  REG_W each  head operands.
- flush  input  1  synchronous discard of all buffered bundles.
- count  output  $clog2(DEPTH)+1  current occupancy.
- full / empty  output  1  occupancy flags.

## Operation
- Push: `exec_clear = exec_valid & ~full & ~flush` (combinational). On the same edge, the bundle is written at wr_ptr and wr_ptr advances.
- Collector contract: on a cycle with exec_clear=1, the collector must, in the next cycle, either drop exec_valid or present a new bundle.
- Pop: `fu_fire = fu_valid & fu_ready`. On fu_fire, rd_ptr advances.
- `fu_valid = ~empty`. fu_* outputs show the entry at rd_ptr and are registered storage, not a combinational pass-through of exec_*.
- Pointers are $clog2(DEPTH)+1 bits wide. The MSB is the wrap bit.
  - empty when pointers are equal.
  - full when the low bits are equal and the MSBs differ.
  - count = wr_ptr − rd_ptr, modulo 2^(width).
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Full: push is blocked even if fu_fire occurs in the same cycle. This avoids a fu_ready → exec_clear path.
- Empty: fu_ready is ignored and there is no underflow.
- Flush: both pointers reset to 0 at the edge; exec_clear=0 that cycle; a fu_fire in that cycle is still accepted by the FU, but the entry is discarded anyway. Flush has priority over push and pop.
- Reset (async, any time, including mid-transfer): pointers=0; count=0; empty=1; full=0; fu_valid=0; exec_clear=0 while rst_n=0. Storage contents are not reset; fu_* data is don't-care while fu_valid=0.

## Timing
- Latency: a bundle accepted at edge N is visible on fu_* with fu_valid=1 in cycle N+1 (one cycle, FIFO previously empty).
- Throughput: one push and one pop per cycle sustained.
- exec_clear depends combinationally on exec_valid, flush, and registered full only.
- fu_valid, full, empty, and count are purely registered.

## Configuration
- GELATO_EXEC_RECV_STATS_EN defined:
  - adds output `stat_issued` (32 b): increments on each fu_fire.
  - adds output `stat_stall` (32 b): increments on each cycle with exec_valid=1 and full=1.
  - both counters wrap at 2^32, reset to 0, and are not cleared by flush.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- Single transfer: FIFO empty; exec_valid=1, inst=0x1234 for one cycle → exec_clear=1 that cycle; next cycle fu_valid=1, fu_inst=0x1234, count=1. fu_ready=1 → next cycle empty=1.
- Back-pressure to full, DEPTH=2, fu_ready=0: three back-to-back bundles A, B, C.
  - exec_clear=1 for A and B; exec_clear=0 while C is held; full=1, count=2.
  - Raise fu_ready for one cycle: A pops; C is taken on the following cycle.
  - Outputs appear in order A, B, C.
- Streaming: fu_ready=1 and 16 consecutive bundles → one per cycle, count stays 1, data in order, and the pointers wrap cleanly.
- Flush: count=2, flush=1 while exec_valid=1 → exec_clear=0; next cycle empty=1, count=0, fu_valid=0. A new bundle is then accepted normally.
- Reset mid-operation: count=1 and exec_valid=1; drop rst_n asynchronously between edges → fu_valid=0, exec_clear=0, and count=0 immediately. After release, the first bundle flows with 1-cycle latency.
- Stats (macro defined): 5 fu_fires and 3 full-stall cycles → stat_issued=5, stat_stall=3. A flush leaves both values unchanged.
